// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg
// Shared types and constants for the program loader that boots
// single_port_sync_ram_large from a framed byte stream.
//   state_t            : loader FSM states
//   ADDR_WIDTH_DEFAULT : default RAM address width
//   ADDR_SPACE         : number of RAM locations at the default width
//   CSUM_WIDTH         : width of the modular frame checksum
package prog_loader_pkg;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE
   } state_t;

   localparam int ADDR_WIDTH_DEFAULT = 8;
   localparam int ADDR_SPACE         = 1 << ADDR_WIDTH_DEFAULT;
   localparam int CSUM_WIDTH         = 8;

endpackage

// File: rtl/prog_loader.sv
// prog_loader
// Accepts a framed byte stream (valid/ready). The first byte of a frame is
// the load/entry address; the following bytes are written to RAM at
// consecutive addresses. When the frame completes cleanly the CPU gets a
// one-cycle cpu_start pulse and a cpu_run level, and the loader releases
// the RAM bus.
//
// Optional build macro: PROG_LOADER_CHECKSUM_EN
//   When defined, the last frame byte is a checksum (8-bit sum of all frame
//   bytes must be 0). It is never written; a mismatch raises load_err.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   in_valid/in_ready/in_data/in_last stream input
//   mem_addr/mem_wdata/mem_cs/mem_we/mem_oe   RAM write port
//   start_addr, cpu_start, cpu_run   CPU boot handoff
//   load_err                         sticky error, cleared by next header
//   byte_count                       payload bytes written this/last frame
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int ADDR_WIDTH = $clog2(ADDR_SPACE),
   parameter int DATA_WIDTH = CSUM_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_last,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_cs,
   output logic                  mem_we,
   output logic                  mem_oe,
   output logic [ADDR_WIDTH-1:0] start_addr,
   output logic                  cpu_start,
   output logic                  cpu_run,
   output logic                  load_err,
   output logic [ADDR_WIDTH-1:0] byte_count
);

   state_t                  state;
   state_t                  next_state;
   logic                    accept;
   logic                    flush;
   logic                    wr_q;
   logic                    wr_req;
   logic                    wr_allowed;
   logic [DATA_WIDTH-1:0]   wr_data;
   logic [ADDR_WIDTH-1:0]   addr_ctr;
   logic [ADDR_WIDTH:0]     cnt;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic                    pend_valid;
   logic [DATA_WIDTH-1:0]   pend_data;
   logic [CSUM_WIDTH-1:0]   sum;
   logic [CSUM_WIDTH-1:0]   csum_total;

   assign csum_total = sum + in_data[CSUM_WIDTH-1:0];
`endif

   assign accept     = in_valid & in_ready;
   assign mem_cs     = wr_q;
   assign mem_we     = wr_q;
   assign mem_oe     = 1'b0;
   assign byte_count = cnt[ADDR_WIDTH-1:0];

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic. flush marks the write cycle of the final byte, so
   // LOAD only hands over to DONE once that write has reached the RAM port.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (accept) next_state = in_last ? DONE : LOAD;
         LOAD:    if (flush)  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // FSM outputs. The loader stops accepting during the final write cycle
   // and the DONE cycle so a following header cannot overlap the handoff.
   always_comb begin
      in_ready  = 1'b0;
      cpu_start = 1'b0;
      case (state)
         IDLE:    in_ready  = 1'b1;
         LOAD:    in_ready  = !flush;
         DONE:    cpu_start = !load_err;
         default: in_ready  = 1'b0;
      endcase
   end

   // Write request for this accepted payload byte. With the checksum build
   // the byte written is the previously pended one, so the final (checksum)
   // byte is never written.
   always_comb begin
      wr_req  = 1'b0;
      wr_data = in_data;
      if (state == LOAD && accept) begin
`ifdef PROG_LOADER_CHECKSUM_EN
         wr_req  = pend_valid;
         wr_data = pend_data;
`else
         wr_req  = 1'b1;
`endif
      end
   end

   // Once every RAM location has been written in this frame, further bytes
   // are accepted but dropped.
   assign wr_allowed = wr_req & !cnt[ADDR_WIDTH];

   // Datapath: header capture, RAM write port, counters, handoff flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_q       <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         addr_ctr   <= '0;
         cnt        <= '0;
         start_addr <= '0;
         load_err   <= 1'b0;
         cpu_run    <= 1'b0;
         flush      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
         pend_valid <= 1'b0;
         pend_data  <= '0;
         sum        <= '0;
`endif
      end else begin
         wr_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  start_addr <= in_data[ADDR_WIDTH-1:0];
                  addr_ctr   <= in_data[ADDR_WIDTH-1:0];
                  cnt        <= '0;
                  cpu_run    <= 1'b0;
                  flush      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
                  pend_valid <= 1'b0;
                  sum        <= in_data[CSUM_WIDTH-1:0];
                  load_err   <= in_last && (in_data[CSUM_WIDTH-1:0] != '0);
`else
                  load_err   <= 1'b0;
`endif
               end
            end
            LOAD: begin
               if (accept) begin
                  if (in_last)
                     flush <= 1'b1;
                  if (wr_allowed) begin
                     mem_addr  <= addr_ctr;
                     mem_wdata <= wr_data;
                     wr_q      <= 1'b1;
                     addr_ctr  <= addr_ctr + 1'b1;
                     cnt       <= cnt + 1'b1;
                     if (&cnt[ADDR_WIDTH-1:0])
                        load_err <= 1'b1;
                  end
`ifdef PROG_LOADER_CHECKSUM_EN
                  if (in_last) begin
                     if (csum_total != '0)
                        load_err <= 1'b1;
                  end else begin
                     pend_data  <= in_data;
                     pend_valid <= 1'b1;
                     sum        <= csum_total;
                  end
`endif
               end
            end
            DONE: begin
               flush <= 1'b0;
               if (!load_err)
                  cpu_run <= 1'b1;
            end
            default: flush <= 1'b0;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader
// Directed self-checking bench for prog_loader. A behavioural RAM captures
// writes on the rising edge after mem_cs/mem_we are presented; cpu_start
// pulses are counted on the falling edge.
module tb_prog_loader;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_last;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_cs;
   logic       mem_we;
   logic       mem_oe;
   logic [7:0] start_addr;
   logic       cpu_start;
   logic       cpu_run;
   logic       load_err;
   logic [7:0] byte_count;

   logic [7:0] ram [256];
   int         writeCount;
   int         cpuStartCount;
   int         testsRun;
   int         testsFailed;
   int         baseWrites;
   int         baseStarts;

   prog_loader dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
      .in_last    (in_last),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_cs     (mem_cs),
      .mem_we     (mem_we),
      .mem_oe     (mem_oe),
      .start_addr (start_addr),
      .cpu_start  (cpu_start),
      .cpu_run    (cpu_run),
      .load_err   (load_err),
      .byte_count (byte_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural RAM write port
   always @(posedge clk) begin
      if (mem_cs === 1'b1 && mem_we === 1'b1) begin
         ram[mem_addr] <= mem_wdata;
         writeCount    <= writeCount + 1;
      end
   end

   // cpu_start pulse counter, sampled mid-cycle
   always @(negedge clk) begin
      if (cpu_start === 1'b1)
         cpuStartCount = cpuStartCount + 1;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      testsRun = testsRun + 1;
      assert (observed === expected)
      else begin
         testsFailed = testsFailed + 1;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Present one byte and hold it until accepted; returns 1 ns after the
   // accepting edge with in_valid dropped.
   task automatic applyStimulus(input logic [7:0] data, input logic last);
      int waitCycles;
      waitCycles = 0;
      in_valid = 1'b1;
      in_data  = data;
      in_last  = last;
      while (in_ready !== 1'b1 && waitCycles < 20) begin
         @(posedge clk);
         #1;
         waitCycles = waitCycles + 1;
      end
      if (waitCycles >= 20) begin
         testsRun    = testsRun + 1;
         testsFailed = testsFailed + 1;
         $display("[TB] FAIL handshake_timeout observed=in_ready_low expected=accept");
      end else begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      writeCount    = 0;
      cpuStartCount = 0;
      testsRun      = 0;
      testsFailed   = 0;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      in_last  = 1'b0;

      // Reset state
      idleCycles(2);
      checkOutput("reset_in_ready",  in_ready,   1);
      checkOutput("reset_mem_cs",    mem_cs,     0);
      checkOutput("reset_cpu_run",   cpu_run,    0);
      checkOutput("reset_cpu_start", cpu_start,  0);
      checkOutput("reset_load_err",  load_err,   0);
      checkOutput("reset_byte_cnt",  byte_count, 0);
      checkOutput("reset_start",     start_addr, 0);
      rst_n = 1'b1;
      idleCycles(1);

`ifdef PROG_LOADER_CHECKSUM_EN
      // Good checksum: 10+01+02+ED = 0x100
      baseWrites = writeCount;
      baseStarts = cpuStartCount;
      applyStimulus(8'h10, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'hED, 1'b1);
      idleCycles(4);
      checkOutput("cs_ram10",   ram[8'h10], 8'h01);
      checkOutput("cs_ram11",   ram[8'h11], 8'h02);
      checkOutput("cs_ram12",   ram[8'h12], 8'h00);
      checkOutput("cs_writes",  writeCount - baseWrites, 2);
      checkOutput("cs_start",   cpuStartCount - baseStarts, 1);
      checkOutput("cs_run",     cpu_run, 1);
      checkOutput("cs_err",     load_err, 0);
      checkOutput("cs_count",   byte_count, 2);

      // Bad checksum
      baseStarts = cpuStartCount;
      applyStimulus(8'h10, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b0);
      applyStimulus(8'hEE, 1'b1);
      idleCycles(4);
      checkOutput("csbad_err",   load_err, 1);
      checkOutput("csbad_start", cpuStartCount - baseStarts, 0);
      checkOutput("csbad_run",   cpu_run, 0);

      // Header-only frames: 00 passes, 40 fails
      baseStarts = cpuStartCount;
      applyStimulus(8'h00, 1'b1);
      idleCycles(3);
      checkOutput("cshdr0_err",   load_err, 0);
      checkOutput("cshdr0_start", cpuStartCount - baseStarts, 1);
      baseStarts = cpuStartCount;
      applyStimulus(8'h40, 1'b1);
      idleCycles(3);
      checkOutput("cshdr40_err",   load_err, 1);
      checkOutput("cshdr40_start", cpuStartCount - baseStarts, 0);
`else
      // Basic frame 00,10,1C,30,1D
      baseWrites = writeCount;
      baseStarts = cpuStartCount;
      applyStimulus(8'h00, 1'b0);
      applyStimulus(8'h10, 1'b0);
      applyStimulus(8'h1C, 1'b0);
      applyStimulus(8'h30, 1'b0);
      applyStimulus(8'h1D, 1'b1);
      checkOutput("f1_ready_final", in_ready, 0);
      idleCycles(4);
      checkOutput("f1_ram0",   ram[8'h00], 8'h10);
      checkOutput("f1_ram1",   ram[8'h01], 8'h1C);
      checkOutput("f1_ram2",   ram[8'h02], 8'h30);
      checkOutput("f1_ram3",   ram[8'h03], 8'h1D);
      checkOutput("f1_writes", writeCount - baseWrites, 4);
      checkOutput("f1_count",  byte_count, 4);
      checkOutput("f1_start",  cpuStartCount - baseStarts, 1);
      checkOutput("f1_saddr",  start_addr, 8'h00);
      checkOutput("f1_run",    cpu_run, 1);
      checkOutput("f1_err",    load_err, 0);
      checkOutput("f1_oe",     mem_oe, 0);

      // Header-only frame 40; cpu_run must drop on the accepting edge
      baseWrites = writeCount;
      baseStarts = cpuStartCount;
      applyStimulus(8'h40, 1'b1);
      checkOutput("f2_run_drop", cpu_run, 0);
      checkOutput("f2_ready_done", in_ready, 0);
      idleCycles(3);
      checkOutput("f2_writes", writeCount - baseWrites, 0);
      checkOutput("f2_start",  cpuStartCount - baseStarts, 1);
      checkOutput("f2_saddr",  start_addr, 8'h40);
      checkOutput("f2_count",  byte_count, 0);
      checkOutput("f2_run",    cpu_run, 1);

      // Address wrap FE,FF,00
      applyStimulus(8'hFE, 1'b0);
      applyStimulus(8'hAA, 1'b0);
      applyStimulus(8'hBB, 1'b0);
      applyStimulus(8'hCC, 1'b1);
      idleCycles(4);
      checkOutput("wrap_ramFE", ram[8'hFE], 8'hAA);
      checkOutput("wrap_ramFF", ram[8'hFF], 8'hBB);
      checkOutput("wrap_ram00", ram[8'h00], 8'hCC);
      checkOutput("wrap_err",   load_err, 0);
      checkOutput("wrap_count", byte_count, 3);

      // Gapped valid: an idle cycle between bytes
      baseWrites = writeCount;
      applyStimulus(8'h20, 1'b0);
      idleCycles(1);
      applyStimulus(8'h5A, 1'b0);
      idleCycles(1);
      checkOutput("gap_ready_load", in_ready, 1);
      applyStimulus(8'h5B, 1'b0);
      idleCycles(1);
      applyStimulus(8'h5C, 1'b1);
      idleCycles(4);
      checkOutput("gap_writes", writeCount - baseWrites, 3);
      checkOutput("gap_ram20",  ram[8'h20], 8'h5A);
      checkOutput("gap_ram21",  ram[8'h21], 8'h5B);
      checkOutput("gap_ram22",  ram[8'h22], 8'h5C);

      // Overflow: 256 payload bytes fill the RAM, the 257th is dropped
      baseWrites = writeCount;
      baseStarts = cpuStartCount;
      applyStimulus(8'h00, 1'b0);
      for (int i = 0; i < 256; i++) applyStimulus(8'(i) ^ 8'h5A, 1'b0);
      applyStimulus(8'hEE, 1'b1);
      idleCycles(4);
      checkOutput("ovf_err",    load_err, 1);
      checkOutput("ovf_writes", writeCount - baseWrites, 256);
      checkOutput("ovf_ram00",  ram[8'h00], 8'h5A);
      checkOutput("ovf_ramFF",  ram[8'hFF], 8'hA5);
      checkOutput("ovf_start",  cpuStartCount - baseStarts, 0);
      checkOutput("ovf_run",    cpu_run, 0);
      checkOutput("ovf_count",  byte_count, 0);

      // Reset in the middle of a frame
      applyStimulus(8'h30, 1'b0);
      applyStimulus(8'h77, 1'b0);
      applyStimulus(8'h88, 1'b0);
      rst_n = 1'b0;
      idleCycles(1);
      rst_n = 1'b1;
      checkOutput("mrst_run",   cpu_run, 0);
      checkOutput("mrst_ready", in_ready, 1);
      checkOutput("mrst_count", byte_count, 0);
      checkOutput("mrst_err",   load_err, 0);
      checkOutput("mrst_cs",    mem_cs, 0);
      idleCycles(1);
      checkOutput("mrst_ram30", ram[8'h30], 8'h77);
      checkOutput("mrst_ram31", ram[8'h31], 8'h88);

      // Normal frame after the reset
      baseStarts = cpuStartCount;
      applyStimulus(8'h50, 1'b0);
      applyStimulus(8'h01, 1'b0);
      applyStimulus(8'h02, 1'b1);
      idleCycles(4);
      checkOutput("post_ram50", ram[8'h50], 8'h01);
      checkOutput("post_ram51", ram[8'h51], 8'h02);
      checkOutput("post_saddr", start_addr, 8'h50);
      checkOutput("post_start", cpuStartCount - baseStarts, 1);
      checkOutput("post_run",   cpu_run, 1);
      checkOutput("post_count", byte_count, 2);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Upstream feeder for single_port_sync_ram_large. Takes a framed byte stream over a valid/ready handshake and writes the payload into RAM at consecutive addresses.
- On frame completion it hands the start address to the fetch sequencer and raises a run enable.
- Replaces hand-sequenced testbench writes with a synthesizable boot path.

Parameters:
- ADDR_WIDTH, 8, RAM address width; address counter wraps modulo 2^ADDR_WIDTH
- DATA_WIDTH, 8, stream and RAM data width; the header byte is an address, so ADDR_WIDTH <= DATA_WIDTH

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  stream byte valid
- in_ready  out  1  loader can accept a byte
- in_data  in  DATA_WIDTH  stream byte
- in_last  in  1  marks final byte of frame
- mem_addr  out  ADDR_WIDTH  RAM address (MAR side)
- mem_wdata  out  DATA_WIDTH  RAM write data, driven onto the RAM data bus
- mem_cs  out  1  RAM chip select
- mem_we  out  1  RAM write enable
- mem_oe  out  1  RAM output enable; always 0 while loader owns the bus
- start_addr  out  ADDR_WIDTH  program entry address (first byte of frame)
- cpu_start  out  1  one-cycle pulse: CPU loads PC <= start_addr
- cpu_run  out  1  level: CPU may fetch; loader has released the bus
- load_err  out  1  sticky error flag, cleared at start of next frame
- byte_count  out  ADDR_WIDTH  payload bytes written in the current or last frame

Behaviour:
- Reset: all outputs 0, except in_ready = 1. State IDLE. Internal counters 0.
- Handshake: a byte is accepted on a rising edge where in_valid & in_ready. in_data and in_last must stay stable while in_valid & !in_ready.
- IDLE:
  - Accepted byte is the header. Register it as base and start_addr.
  - addr_ctr <= base, byte_count <= 0, load_err <= 0, cpu_run <= 0.
  - If in_last is set with the header, go to DONE (empty frame, valid). Otherwise go to LOAD.
- LOAD:
  - Each accepted byte registers mem_addr <= addr_ctr, mem_wdata <= byte, mem_cs = mem_we = 1 for exactly that next cycle, so the RAM captures it on the following edge.
  - Then addr_ctr += 1, byte_count += 1.
  - Sustains one byte per cycle; in_ready stays 1 in LOAD.
- Wrap: addr_ctr wraps past 2^ADDR_WIDTH-1 to 0 and writing continues.
  - If byte_count reaches 2^ADDR_WIDTH (RAM would be overwritten), set load_err.
  - Remaining bytes of the frame are accepted and dropped, with no writes.
- in_last accepted in LOAD: after the final write cycle, go to DONE.
- DONE (1 cycle):
  - in_ready = 0, mem_cs = mem_we = 0.
  - If !load_err: cpu_start = 1 and cpu_run <= 1.
  - Then go to IDLE.
- cpu_run:
  - Held 1 until the next header is accepted.
  - While cpu_run = 1, mem_cs/mem_we/mem_oe are 0 so the CPU owns the bus.
- Mid-operation reset: frame abandoned, return to IDLE, cpu_run = 0. Bytes already written to RAM are not undone.
- A header arriving while cpu_run = 1 drops cpu_run on the accepting edge; the CPU must stop fetching.

Optional Feature:
- Macro: PROG_LOADER_CHECKSUM_EN.
- Enabled:
  - The final frame byte is a checksum. The 8-bit modular sum of header, payload and checksum must equal 0.
  - Writes are delayed one byte through a pending register so the checksum byte is never written to RAM.
  - Mismatch sets load_err, and no cpu_start is issued.
  - A header-only frame is treated as checksum = header and passes only if the header is 0x00.
- Disabled: no pending register; every post-header byte is written; no checksum check.

Decomposition:
- Package prog_loader_pkg holds:
  - state enum {IDLE, LOAD, DONE}
  - localparam ADDR_SPACE = 1 << ADDR_WIDTH
  - checksum width constant
- No sub-module needed. The RAM write port driver stays inline; the checksum accumulator is a few lines under the macro.

Test Plan:
- Frame 00,10,1C,30,1D (last on 1D), CHECKSUM off -> RAM[00..03] = 10,1C,30,1D; byte_count = 4; cpu_start pulse with start_addr = 00; cpu_run = 1.
- Header 40 with in_last, no payload -> no writes; cpu_start with start_addr = 40; byte_count = 0.
- Header FE then bytes AA,BB,CC -> RAM[FE] = AA, RAM[FF] = BB, RAM[00] = CC (wrap); load_err = 0.
- in_valid toggled every other cycle and in_ready observed -> writes occur only on accepted bytes; addresses are contiguous.
- CHECKSUM on, frame 10,01,02,ED -> RAM[10..11] = 01,02; RAM[12] untouched; cpu_start. Same frame with last byte EE -> load_err = 1; no cpu_start; cpu_run = 0.
- rst_n low for 1 cycle after 2 payload bytes -> state IDLE; cpu_run = 0; next frame loads normally.
